// File: rtl/axi4l_mem_responder.sv
// AXI4-Lite responder backed by a byte-strobed, word-addressed local memory.
// Out-of-window accesses complete with SLVERR; writes are dropped, reads return zero.
module axi4l_mem_responder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    MEM_SIZE   = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic [2:0]              awprot_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [1:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  input  logic [ADDR_WIDTH-1:0]   araddr_i,
  input  logic [2:0]              arprot_i,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    rvalid_o,
  input  logic                    rready_i
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned OFF   = $clog2(NB);
  localparam int unsigned DEPTH = MEM_SIZE / NB;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // One extra bit so BASE_ADDR+MEM_SIZE cannot wrap at the top of the address space.
  localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + (ADDR_WIDTH+1)'(MEM_SIZE);

  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= WIN_LO) && ({1'b0, a} < WIN_HI);
  endfunction

  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] rel;
    rel = a - BASE_ADDR;
    return IDX_W'(rel >> OFF);
  endfunction

  logic                  aw_full;
  logic                  aw_ok;
  logic [IDX_W-1:0]      aw_idx;
  logic                  w_full;
  logic [DATA_WIDTH-1:0] w_data;
  logic [NB-1:0]         w_strb;
  logic                  fire;
  logic                  ar_fire;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic unused_prot;
  assign unused_prot = ^{awprot_i, arprot_i};

  assign awready_o = !aw_full;
  assign wready_o  = !w_full;
  assign arready_o = !rvalid_o || rready_i;
  assign fire      = aw_full && w_full && (!bvalid_o || bready_i);
  assign ar_fire   = arvalid_i && arready_o;

  // Window decode is done at AW capture so the fire path only sees registered state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_full  <= 1'b0;
      aw_ok    <= 1'b0;
      aw_idx   <= '0;
      w_full   <= 1'b0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_o <= 1'b0;
      bresp_o  <= RESP_OKAY;
    end else begin
      if (awvalid_i && awready_o) begin
        aw_full <= 1'b1;
        aw_ok   <= in_window(awaddr_i);
        aw_idx  <= word_index(awaddr_i);
      end else if (fire) begin
        aw_full <= 1'b0;
      end

      if (wvalid_i && wready_o) begin
        w_full <= 1'b1;
        w_data <= wdata_i;
        w_strb <= wstrb_i;
      end else if (fire) begin
        w_full <= 1'b0;
      end

      if (fire) begin
        bvalid_o <= 1'b1;
        bresp_o  <= aw_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bready_i) begin
        bvalid_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (fire && aw_ok) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (w_strb[b]) begin
          mem[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
    end
  end

  // Reads sample mem before the same-edge write lands, giving pre-write data on collision.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      rresp_o  <= RESP_OKAY;
    end else if (ar_fire) begin
      rvalid_o <= 1'b1;
      if (in_window(araddr_i)) begin
        rdata_o <= mem[word_index(araddr_i)];
        rresp_o <= RESP_OKAY;
      end else begin
        rdata_o <= '0;
        rresp_o <= RESP_SLVERR;
      end
    end else if (rready_i) begin
      rvalid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4l_mem_responder.sv
// Scoreboard bench for axi4l_mem_responder: a word model predicts responses, queued per channel.
module tb_axi4l_mem_responder;

  logic        clk, rst;
  logic [31:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic [1:0]  exp_b[$];
  rexp_t       exp_r[$];
  logic [63:0] model [512];

  axi4l_mem_responder #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(64),
    .MEM_SIZE(4096),
    .BASE_ADDR(32'h0000_0000)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .awaddr_i(awaddr), .awprot_i(awprot), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
    .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .araddr_i(araddr), .arprot_i(arprot), .arvalid_i(arvalid), .arready_o(arready),
    .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic win(input logic [31:0] a);
    return a < 32'h1000;
  endfunction

  function automatic void model_wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    if (win(a)) begin
      for (int b = 0; b < 8; b++) begin
        if (s[b]) model[a[11:3]][8*b +: 8] = d[8*b +: 8];
      end
    end
    exp_b.push_back(win(a) ? 2'b00 : 2'b10);
  endfunction

  function automatic void model_rd(input logic [31:0] a);
    rexp_t e;
    e.data = win(a) ? model[a[11:3]] : 64'h0;
    e.resp = win(a) ? 2'b00 : 2'b10;
    exp_r.push_back(e);
  endfunction

  // Same-cycle AW+W write; lat counts edges from both-captured to bvalid seen.
  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          output logic [1:0] resp, output int lat, output bit to);
    bit aw_done, w_done, aw_go, w_go;
    int n;
    model_wr(a, d, s);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 0; w_done = 0; to = 0; n = 0;
    while (!(aw_done && w_done)) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      @(posedge clk); #1; n++;
      if (aw_go) begin awvalid = 1'b0; aw_done = 1; end
      if (w_go)  begin wvalid  = 1'b0; w_done  = 1; end
      if (n > 50) begin to = 1; break; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 0;
    while (!bvalid && !to) begin
      @(posedge clk); #1; lat++;
      if (lat > 50) to = 1;
    end
    resp = bresp;
    @(posedge clk); #1;
  endtask

  // lat counts edges from the AR handshake edge (inclusive) until rvalid is seen.
  task automatic do_read(input logic [31:0] a, output logic [63:0] d, output logic [1:0] resp,
                         output int lat, output bit to);
    bit go;
    int n;
    model_rd(a);
    araddr = a; arvalid = 1'b1; n = 0; to = 0;
    while (1) begin
      go = arready;
      @(posedge clk); #1; n++;
      if (go) break;
      if (n > 50) begin to = 1; break; end
    end
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && !to) begin
      @(posedge clk); #1; lat++;
      if (lat > 50) to = 1;
    end
    d = rdata; resp = rresp;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [63:0] d; logic [1:0] r; int lat; bit to; rexp_t e;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 512; i++) model[i] = '0;
    total++; if (awready !== 1'b1) $display("FAIL reset_awready: got %b, expected 1", awready); else passed++;
    total++; if (wready !== 1'b1) $display("FAIL reset_wready: got %b, expected 1", wready); else passed++;
    total++; if (arready !== 1'b1) $display("FAIL reset_arready: got %b, expected 1", arready); else passed++;
    total++; if (bvalid !== 1'b0) $display("FAIL reset_bvalid: got %b, expected 0", bvalid); else passed++;
    total++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b, expected 0", rvalid); else passed++;
    do_read(32'h10, d, r, lat, to);
    e = exp_r.pop_front();
    total++; if (to || d !== e.data || r !== e.resp)
      $display("FAIL reset_read: got data %h resp %b, expected data %h resp %b", d, r, e.data, e.resp);
    else passed++;
  endtask

  task automatic test_full_write();
    logic [63:0] d; logic [1:0] r; int lat; bit to; logic [1:0] eb; rexp_t e;
    do_write(32'h8, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, r, lat, to);
    eb = exp_b.pop_front();
    total++; if (to || r !== eb) $display("FAIL full_write_bresp: got %b, expected %b", r, eb); else passed++;
    total++; if (lat !== 1) $display("FAIL full_write_latency: got %0d, expected 1", lat); else passed++;
    do_read(32'h8, d, r, lat, to);
    e = exp_r.pop_front();
    total++; if (to || d !== e.data || r !== e.resp)
      $display("FAIL full_write_read: got data %h resp %b, expected data %h resp %b", d, r, e.data, e.resp);
    else passed++;
    total++; if (lat !== 1) $display("FAIL read_latency: got %0d, expected 1", lat); else passed++;
  endtask

  task automatic test_partial_strobe();
    logic [63:0] d; logic [1:0] r; int lat; bit to; logic [1:0] eb; rexp_t e;
    do_write(32'h8, 64'h1111_2222_3333_4444, 8'hFF, r, lat, to);
    eb = exp_b.pop_front();
    total++; if (to || r !== eb) $display("FAIL strobe_write1: got %b, expected %b", r, eb); else passed++;
    do_write(32'h8, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, r, lat, to);
    eb = exp_b.pop_front();
    total++; if (to || r !== eb) $display("FAIL strobe_write2: got %b, expected %b", r, eb); else passed++;
    do_read(32'h8, d, r, lat, to);
    e = exp_r.pop_front();
    total++; if (to || d !== e.data || d !== 64'h1111_2222_FFFF_FFFF)
      $display("FAIL strobe_read: got %h, expected %h", d, e.data);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [63:0] d; logic [1:0] r; int lat; bit to; logic [1:0] eb; rexp_t e;
    bready = 1'b0;
    model_wr(32'h10, 64'hA5A5_0123_4567_89AB, 8'hFF);
    wdata = 64'hA5A5_0123_4567_89AB; wstrb = 8'hFF; wvalid = 1'b1;
    @(posedge clk); #1; wvalid = 1'b0;
    total++; if (wready !== 1'b0 || awready !== 1'b1)
      $display("FAIL w_first_held: got wready %b awready %b, expected 0 1", wready, awready);
    else passed++;
    repeat (2) @(posedge clk);
    #1 awaddr = 32'h10; awvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0;
    @(posedge clk); #1;
    total++; if (bvalid !== 1'b1) $display("FAIL w_first_bvalid: got %b, expected 1", bvalid); else passed++;
    model_wr(32'h1008, 64'h5555_6666_7777_8888, 8'hFF);
    awaddr = 32'h1008; wdata = 64'h5555_6666_7777_8888; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
    eb = exp_b.pop_front();
    for (int i = 0; i < 3; i++) begin
      total++; if (bvalid !== 1'b1 || bresp !== eb || awready !== 1'b0 || wready !== 1'b0)
        $display("FAIL b_hold: got bvalid %b bresp %b awready %b wready %b, expected 1 %b 0 0",
                 bvalid, bresp, awready, wready, eb);
      else passed++;
      @(posedge clk); #1;
    end
    bready = 1'b1;
    eb = exp_b.pop_front();
    @(posedge clk); #1;
    total++; if (bvalid !== 1'b1 || bresp !== eb)
      $display("FAIL second_write_b: got bvalid %b bresp %b, expected 1 %b", bvalid, bresp, eb);
    else passed++;
    @(posedge clk); #1;
    total++; if (bvalid !== 1'b0) $display("FAIL second_write_done: got %b, expected 0", bvalid); else passed++;
    do_read(32'h10, d, r, lat, to);
    e = exp_r.pop_front();
    total++; if (to || d !== e.data || r !== e.resp)
      $display("FAIL backpressure_read: got %h %b, expected %h %b", d, r, e.data, e.resp);
    else passed++;
  endtask

  task automatic test_out_of_window();
    logic [63:0] d; logic [1:0] r; int lat; bit to; logic [1:0] eb; rexp_t e;
    logic [31:0] addrs [2];
    do_write(32'h1000, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, r, lat, to);
    eb = exp_b.pop_front();
    total++; if (to || r !== eb) $display("FAIL oow_bresp: got %b, expected %b", r, eb); else passed++;
    do_read(32'h0, d, r, lat, to);
    e = exp_r.pop_front();
    total++; if (to || d !== e.data || r !== e.resp)
      $display("FAIL oow_mem_unchanged: got %h %b, expected %h %b", d, r, e.data, e.resp);
    else passed++;
    do_read(32'h1000, d, r, lat, to);
    e = exp_r.pop_front();
    total++; if (to || d !== e.data || r !== e.resp)
      $display("FAIL oow_read: got %h %b, expected %h %b", d, r, e.data, e.resp);
    else passed++;
    addrs[0] = 32'h0; addrs[1] = 32'h8;
    rready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      model_rd(addrs[k]);
      araddr = addrs[k]; arvalid = 1'b1;
      @(posedge clk); #1;
      e = exp_r.pop_front();
      total++; if (rvalid !== 1'b1 || rdata !== e.data || rresp !== e.resp)
        $display("FAIL b2b_read%0d: got rvalid %b data %h resp %b, expected 1 %h %b",
                 k, rvalid, rdata, rresp, e.data, e.resp);
      else passed++;
    end
    arvalid = 1'b0;
    @(posedge clk); #1;
    total++; if (rvalid !== 1'b0) $display("FAIL b2b_drain: got %b, expected 0", rvalid); else passed++;
  endtask

  task automatic test_collision();
    logic [63:0] d; logic [1:0] r; int lat; bit to; logic [1:0] eb; rexp_t e;
    do_write(32'h20, 64'h0123_4567_89AB_CDEF, 8'hFF, r, lat, to);
    eb = exp_b.pop_front();
    total++; if (to || r !== eb) $display("FAIL coll_setup: got %b, expected %b", r, eb); else passed++;
    model_rd(32'h20);
    model_wr(32'h20, 64'hFEDC_BA98_7654_3210, 8'hFF);
    awaddr = 32'h20; wdata = 64'hFEDC_BA98_7654_3210; wstrb = 8'hFF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h20; arvalid = 1'b1;
    @(posedge clk); #1; arvalid = 1'b0;
    e = exp_r.pop_front();
    eb = exp_b.pop_front();
    total++; if (rvalid !== 1'b1 || rdata !== e.data)
      $display("FAIL coll_old_data: got rvalid %b data %h, expected 1 %h", rvalid, rdata, e.data);
    else passed++;
    total++; if (bvalid !== 1'b1 || bresp !== eb)
      $display("FAIL coll_bvalid: got %b %b, expected 1 %b", bvalid, bresp, eb);
    else passed++;
    @(posedge clk); #1;
    do_read(32'h20, d, r, lat, to);
    e = exp_r.pop_front();
    total++; if (to || d !== e.data) $display("FAIL coll_new_data: got %h, expected %h", d, e.data); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] d; logic [1:0] r; int lat; bit to; rexp_t e;
    rready = 1'b0;
    awaddr = 32'h8; awvalid = 1'b1;
    araddr = 32'h8; arvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0; arvalid = 1'b0;
    total++; if (awready !== 1'b0 || rvalid !== 1'b1)
      $display("FAIL mid_precond: got awready %b rvalid %b, expected 0 1", awready, rvalid);
    else passed++;
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; rready = 1'b1;
    for (int i = 0; i < 512; i++) model[i] = '0;
    total++; if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1)
      $display("FAIL mid_readies: got %b %b %b, expected 1 1 1", awready, wready, arready);
    else passed++;
    total++; if (bvalid !== 1'b0 || rvalid !== 1'b0 || bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 64'h0)
      $display("FAIL mid_outputs: got bv %b rv %b br %b rr %b rd %h, expected 0 0 00 00 0",
               bvalid, rvalid, bresp, rresp, rdata);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++; if (bvalid !== 1'b0 || rvalid !== 1'b0)
        $display("FAIL mid_no_response: got bvalid %b rvalid %b, expected 0 0", bvalid, rvalid);
      else passed++;
    end
    do_read(32'h8, d, r, lat, to);
    e = exp_r.pop_front();
    total++; if (to || d !== e.data) $display("FAIL mid_mem_cleared_8: got %h, expected %h", d, e.data); else passed++;
    do_read(32'h20, d, r, lat, to);
    e = exp_r.pop_front();
    total++; if (to || d !== e.data) $display("FAIL mid_mem_cleared_20: got %h, expected %h", d, e.data); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    test_reset();
    test_full_write();
    test_partial_strobe();
    test_backpressure();
    test_out_of_window();
    test_collision();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
